mem_io_ctrl: RTL and testbench

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

---
 rtl/mem_io_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_io_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - memory/IO access sequencer with keyboard and display device registers
module mem_io_ctrl #(
   parameter int MEM_LATENCY = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MIO_EN,
   input  logic        R_W,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic        KB_STROBE,
   input  logic [7:0]  KB_DATA,
   input  logic        DISP_ACK,
   output logic        MEM_EN,
   output logic        MEM_WE,
   output logic        R,
   output logic [1:0]  INMUX_SEL,
   output logic [15:0] KBDR_OUT,
   output logic [15:0] KBSR_OUT,
   output logic [15:0] DSR_OUT,
   output logic [15:0] DDR_OUT,
   output logic        DDR_VALID
);

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;

   localparam logic [1:0] SEL_KBDR = 2'b00;
   localparam logic [1:0] SEL_KBSR = 2'b01;
   localparam logic [1:0] SEL_DSR  = 2'b10;
   localparam logic [1:0] SEL_MEM  = 2'b11;

   // last value of the wait counter before leaving MEM_WAIT
   localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      DONE     = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        accept;
   logic [3:0]  wait_cnt;

   logic [15:0] mar_q;
   logic [15:0] mdr_q;
   logic        rw_q;
   logic [1:0]  sel_q;

   logic        req_is_dev;
   logic [1:0]  req_sel;

   logic [7:0]  kb_char;
   logic        kb_full;
   logic        disp_ready;
   logic [15:0] ddr_q;
   logic        ddr_valid_q;

   logic        kbdr_read_done;
   logic        ddr_write_done;

   // decode the live request address into device/memory and read-source select
   always_comb begin
      req_is_dev = 1'b1;
      req_sel    = SEL_MEM;
      case (MAR)
         KBSR_ADDR: req_sel = SEL_KBSR;
         KBDR_ADDR: req_sel = SEL_KBDR;
         DSR_ADDR:  req_sel = SEL_DSR;
         DDR_ADDR:  req_sel = SEL_MEM;
         default:   req_is_dev = 1'b0;
      endcase
   end

   // state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and per-state strobes
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      MEM_EN  = 1'b0;
      MEM_WE  = 1'b0;
      R       = 1'b0;
      case (state_q)
         IDLE: begin
            if (MIO_EN) begin
               accept  = 1'b1;
               state_d = req_is_dev ? DONE : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            MEM_EN = 1'b1;
            MEM_WE = rw_q;
            if (wait_cnt == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            R       = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // count memory-enable cycles; cleared whenever MEM_WAIT is not continuing
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wait_cnt <= 4'd0;
      end else if (state_q == MEM_WAIT && state_d == MEM_WAIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end else begin
         wait_cnt <= 4'd0;
      end
   end

   // capture the request when it is accepted; select holds until the next accept
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mar_q <= 16'h0000;
         mdr_q <= 16'h0000;
         rw_q  <= 1'b0;
         sel_q <= SEL_MEM;
      end else if (accept) begin
         mar_q <= MAR;
         mdr_q <= MDR;
         rw_q  <= R_W;
         sel_q <= req_sel;
      end
   end

   // device side effects happen only on the edge that ends DONE
   assign kbdr_read_done = (state_q == DONE) && !rw_q && (mar_q == KBDR_ADDR);
   assign ddr_write_done = (state_q == DONE) &&  rw_q && (mar_q == DDR_ADDR);

   // keyboard: a new character lands if the buffer is empty or is being read this edge
   always_ff @(posedge CLK) begin
      if (RESET) begin
         kb_char <= 8'h00;
         kb_full <= 1'b0;
      end else if (KB_STROBE && (!kb_full || kbdr_read_done)) begin
         kb_char <= KB_DATA;
         kb_full <= 1'b1;
      end else if (kbdr_read_done) begin
         kb_full <= 1'b0;
      end
   end

   // display: a write is taken only while ready; the acknowledge re-arms ready
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ddr_q       <= 16'h0000;
         ddr_valid_q <= 1'b0;
         disp_ready  <= 1'b1;
      end else if (ddr_write_done && disp_ready) begin
         ddr_q       <= mdr_q;
         ddr_valid_q <= 1'b1;
         disp_ready  <= 1'b0;
      end else if (DISP_ACK && ddr_valid_q) begin
         ddr_valid_q <= 1'b0;
         disp_ready  <= 1'b1;
      end
   end

   assign INMUX_SEL = sel_q;
   assign KBDR_OUT  = {8'h00, kb_char};
   assign KBSR_OUT  = {kb_full, 15'h0000};
   assign DSR_OUT   = {disp_ready, 15'h0000};
   assign DDR_OUT   = ddr_q;
   assign DDR_VALID = ddr_valid_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb/tb_mem_io_ctrl.sv - directed and randomized checks of mem_io_ctrl against a timing model
module tb_mem_io_ctrl;

   localparam int L = 3;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        MIO_EN = 1'b0;
   logic        R_W = 1'b0;
   logic [15:0] MAR = 16'h0000;
   logic [15:0] MDR = 16'h0000;
   logic        KB_STROBE = 1'b0;
   logic [7:0]  KB_DATA = 8'h00;
   logic        DISP_ACK = 1'b0;
   logic        MEM_EN;
   logic        MEM_WE;
   logic        R;
   logic [1:0]  INMUX_SEL;
   logic [15:0] KBDR_OUT;
   logic [15:0] KBSR_OUT;
   logic [15:0] DSR_OUT;
   logic [15:0] DDR_OUT;
   logic        DDR_VALID;

   mem_io_ctrl #(.MEM_LATENCY(L)) dut (
      .CLK(CLK), .RESET(RESET), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR), .MDR(MDR),
      .KB_STROBE(KB_STROBE), .KB_DATA(KB_DATA), .DISP_ACK(DISP_ACK),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .R(R), .INMUX_SEL(INMUX_SEL),
      .KBDR_OUT(KBDR_OUT), .KBSR_OUT(KBSR_OUT), .DSR_OUT(DSR_OUT),
      .DDR_OUT(DDR_OUT), .DDR_VALID(DDR_VALID)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // transaction-level model: cycle number of acceptance plus device contents
   int          cyc = 0;
   int          acc_start = 0;
   bit          in_acc = 1'b0;
   bit          acc_mem = 1'b0;
   bit          acc_rw = 1'b0;
   logic [15:0] acc_addr = 16'h0000;
   logic [15:0] acc_mdr = 16'h0000;
   logic [1:0]  m_sel = 2'b11;
   logic [7:0]  m_kb = 8'h00;
   bit          m_kb_full = 1'b0;
   bit          m_disp_ready = 1'b1;
   bit          m_ddr_valid = 1'b0;
   logic [15:0] m_ddr = 16'h0000;

   function automatic bit is_dev(logic [15:0] a);
      return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
   endfunction

   function automatic logic [1:0] sel_of(logic [15:0] a);
      if (a == 16'hFE00) return 2'b01;
      if (a == 16'hFE02) return 2'b00;
      if (a == 16'hFE04) return 2'b10;
      return 2'b11;
   endfunction

   function automatic int done_off();
      return acc_mem ? L + 1 : 1;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step(input bit rst, input bit mio, input bit rw, input logic [15:0] mar,
                             input logic [15:0] mdr, input bit kbs, input logic [7:0] kbd,
                             input bit ack);
      bit done_now;
      bit kb_rd;
      bit ddr_wr;
      if (rst) begin
         in_acc = 1'b0; m_sel = 2'b11; m_kb = 8'h00; m_kb_full = 1'b0;
         m_disp_ready = 1'b1; m_ddr_valid = 1'b0; m_ddr = 16'h0000;
      end else begin
         done_now = in_acc && ((cyc - acc_start) == done_off());
         kb_rd  = done_now && !acc_rw && (acc_addr == 16'hFE02);
         ddr_wr = done_now &&  acc_rw && (acc_addr == 16'hFE06);
         if (kbs && (!m_kb_full || kb_rd)) begin
            m_kb = kbd; m_kb_full = 1'b1;
         end else if (kb_rd) begin
            m_kb_full = 1'b0;
         end
         if (ddr_wr && m_disp_ready) begin
            m_ddr = acc_mdr; m_ddr_valid = 1'b1; m_disp_ready = 1'b0;
         end else if (ack && m_ddr_valid) begin
            m_ddr_valid = 1'b0; m_disp_ready = 1'b1;
         end
         if (done_now) begin
            in_acc = 1'b0;
         end else if (!in_acc && mio) begin
            in_acc = 1'b1; acc_start = cyc; acc_mem = !is_dev(mar);
            acc_rw = rw; acc_addr = mar; acc_mdr = mdr; m_sel = sel_of(mar);
         end
      end
      cyc++;
   endtask

   // compare every DUT output with what the model says this cycle must show
   task automatic compare_all();
      int  off;
      bit  e_en;
      bit  e_r;
      off  = cyc - acc_start;
      e_en = in_acc && acc_mem && (off >= 1) && (off <= L);
      e_r  = in_acc && (off == done_off());
      chk("mem_en",    {15'h0, MEM_EN},    {15'h0, e_en});
      chk("mem_we",    {15'h0, MEM_WE},    {15'h0, e_en && acc_rw});
      chk("r",         {15'h0, R},         {15'h0, e_r});
      chk("inmux_sel", {14'h0, INMUX_SEL}, {14'h0, m_sel});
      chk("kbdr",      KBDR_OUT,           {8'h00, m_kb});
      chk("kbsr",      KBSR_OUT,           {m_kb_full, 15'h0});
      chk("dsr",       DSR_OUT,            {m_disp_ready, 15'h0});
      chk("ddr",       DDR_OUT,            m_ddr);
      chk("ddr_valid", {15'h0, DDR_VALID}, {15'h0, m_ddr_valid});
   endtask

   // drive one cycle of inputs, advance model, then compare after the edge
   task automatic step(input bit rst, input bit mio, input bit rw, input logic [15:0] mar,
                       input logic [15:0] mdr, input bit kbs, input logic [7:0] kbd,
                       input bit ack);
      RESET = rst; MIO_EN = mio; R_W = rw; MAR = mar; MDR = mdr;
      KB_STROBE = kbs; KB_DATA = kbd; DISP_ACK = ack;
      model_step(rst, mio, rw, mar, mdr, kbs, kbd, ack);
      @(posedge CLK);
      @(negedge CLK);
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0);
   endtask

   initial begin
      logic [15:0] a;
      logic [15:0] d;
      @(negedge CLK);
      step(1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0);
      chk("rst_sel", {14'h0, INMUX_SEL}, 16'h0003);
      chk("rst_dsr", DSR_OUT, 16'h8000);
      chk("rst_kbsr", KBSR_OUT, 16'h0000);
      chk("rst_r", {15'h0, R}, 16'h0000);

      // memory read at x3000
      step(0, 1, 0, 16'h3000, 16'h0000, 0, 8'h00, 0);
      chk("mrd_en1", {15'h0, MEM_EN}, 16'h0001);
      chk("mrd_we1", {15'h0, MEM_WE}, 16'h0000);
      idle(); idle();
      chk("mrd_en3", {15'h0, MEM_EN}, 16'h0001);
      chk("mrd_r3", {15'h0, R}, 16'h0000);
      idle();
      chk("mrd_r4", {15'h0, R}, 16'h0001);
      chk("mrd_en4", {15'h0, MEM_EN}, 16'h0000);
      chk("mrd_sel", {14'h0, INMUX_SEL}, 16'h0003);
      idle();
      chk("mrd_r5", {15'h0, R}, 16'h0000);

      // keyboard load, drop, same-edge reload, then a plain read clears
      step(0, 0, 0, 16'h0000, 16'h0000, 1, 8'h41, 0);
      chk("kb_kbsr", KBSR_OUT, 16'h8000);
      chk("kb_kbdr", KBDR_OUT, 16'h0041);
      step(0, 0, 0, 16'h0000, 16'h0000, 1, 8'h42, 0);
      chk("kb_drop", KBDR_OUT, 16'h0041);
      step(0, 1, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0);
      chk("kb_rd_r", {15'h0, R}, 16'h0001);
      chk("kb_rd_sel", {14'h0, INMUX_SEL}, 16'h0000);
      step(0, 0, 0, 16'h0000, 16'h0000, 1, 8'h43, 0);
      chk("kb_win_kbdr", KBDR_OUT, 16'h0043);
      chk("kb_win_kbsr", KBSR_OUT, 16'h8000);
      step(0, 1, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0);
      idle();
      chk("kb_clr", KBSR_OUT, 16'h0000);

      // display write, ignored second write, acknowledge
      step(0, 1, 1, 16'hFE06, 16'h0048, 0, 8'h00, 0);
      idle();
      chk("ddr_out", DDR_OUT, 16'h0048);
      chk("ddr_valid", {15'h0, DDR_VALID}, 16'h0001);
      chk("ddr_dsr", DSR_OUT, 16'h0000);
      step(0, 1, 1, 16'hFE06, 16'h0049, 0, 8'h00, 0);
      idle();
      chk("ddr_ign", DDR_OUT, 16'h0048);
      step(0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 1);
      chk("ack_valid", {15'h0, DDR_VALID}, 16'h0000);
      chk("ack_dsr", DSR_OUT, 16'h8000);

      // back-to-back device reads with MIO_EN held high
      step(0, 1, 0, 16'hFE00, 16'h0000, 0, 8'h00, 0);
      chk("b2b_r1", {15'h0, R}, 16'h0001);
      chk("b2b_sel1", {14'h0, INMUX_SEL}, 16'h0001);
      step(0, 1, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0);
      chk("b2b_r2", {15'h0, R}, 16'h0000);
      step(0, 1, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0);
      chk("b2b_r3", {15'h0, R}, 16'h0001);
      chk("b2b_sel3", {14'h0, INMUX_SEL}, 16'h0002);
      idle();

      // reset during DONE of a display write, and during MEM_WAIT of a memory write
      step(0, 1, 1, 16'hFE06, 16'h0055, 1, 8'h61, 0);
      step(1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0);
      chk("rst_ddr_out", DDR_OUT, 16'h0000);
      chk("rst_ddr_valid", {15'h0, DDR_VALID}, 16'h0000);
      chk("rst_kbdr", KBDR_OUT, 16'h0000);
      step(0, 1, 1, 16'h4000, 16'h1234, 0, 8'h00, 0);
      idle();
      step(1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0);
      chk("abort_en", {15'h0, MEM_EN}, 16'h0000);
      chk("abort_r", {15'h0, R}, 16'h0000);
      idle(); idle(); idle();
      chk("abort_nor", {15'h0, R}, 16'h0000);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 7))
            0: a = 16'hFE00;
            1: a = 16'hFE02;
            2: a = 16'hFE04;
            3, 4: a = 16'hFE06;
            5: a = 16'hFE01;
            default: a = 16'($urandom);
         endcase
         d = 16'($urandom);
         step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              a, d, ($urandom_range(0, 4) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
